pe_mx: RTL and testbench
========================

Name: pe_mx

Overview:
- Parametrised successor to the single-format FP8 systolic processing element.
- Accepts FP8 operand pairs in E4M3 or E5M2, selectable at runtime, with a valid qualifier.
- Pipelined as multiply/decode then align/accumulate, into a signed fixed-point accumulator of configurable width.
- Sits in the systolic array grid: forwards operands east and south each cycle; results leave through an explicit drain handshake.

Parameters:
- ACC_W, 24: accumulator and result width in bits, signed two's complement; legal range 16..32.
- FRAC_BITS, 8: fractional bits of the accumulator fixed-point format.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- clear  in  1  synchronous accumulator/flag clear.
- fmt  in  1  0 = E4M3 (bias 7, 3 mantissa bits); 1 = E5M2 (bias 15, 2 mantissa bits).
- in_valid  in  1  a_in/b_in carry a product to accumulate.
- a_in  in  8  FP8 operand A.
- b_in  in  8  FP8 operand B.
- a_out  out  8  a_in delayed one cycle.
- b_out  out  8  b_in delayed one cycle.
- valid_out  out  1  in_valid delayed one cycle.
- drain  in  1  request result snapshot.
- c_out  out  ACC_W  drained accumulator value.
- c_valid  out  1  one-cycle pulse when c_out is updated.
- nan_seen  out  1  sticky: a special-value operand was consumed since the last clear.
- ovf  out  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (rst==0 at an edge): every register and output goes to 0, including both pipeline stages.
- Forwarding: a_out, b_out and valid_out take a_in, b_in and in_valid on every edge, unconditionally.
- Decode:
  - Subnormal: exp field == 0 gives effective exponent 1 and hidden bit 0.
  - Otherwise the hidden bit is 1.
  - E5M2 mantissa is left-aligned to 3 bits (append a 0).
  - The product's 8-bit magnitude is {h,m}*{h,m}.
- Specials:
  - E4M3 S.1111.111 is a special value.
  - Any E5M2 operand with exp == 31 is a special value.
  - When either operand is special, the product magnitude is forced to 0 and nan_seen is set when the product retires in stage 2.
- Stage 1 register (captured when in_valid == 1, else holds a bubble with valid 0):
  - sign = sa^sb.
  - 8-bit mantissa product.
  - signed shift s = ea+eb-2*bias-6+FRAC_BITS.
- Stage 2 alignment:
  - s >= 0: magnitude = prod << s.
  - If the shifted magnitude exceeds 2^(ACC_W-1)-1, clamp it to 2^(ACC_W-1)-1 and treat it as an overflow event.
  - s < 0: magnitude = prod >> -s, truncating toward zero; -s >= 8 yields 0.
- Accumulate: acc_next = acc ± magnitude, using sign. A bubble adds 0.
- Latency: a product presented at edge t updates acc at edge t+1; drain at edge t+1 includes it.
- Drain: at an edge with drain == 1:
  - c_out <= acc_next.
  - c_valid <= 1 for exactly one cycle; otherwise c_valid <= 0 and c_out holds its value.
- Clear: at an edge with clear == 1:
  - acc, nan_seen and ovf go to 0; the stage-2 product in flight that cycle is discarded.
  - Stage 1 still captures normally, so a product issued alongside clear lands in the fresh accumulator.
- clear and drain together: c_out gets the pre-clear acc_next and acc restarts at 0, giving seamless tile turnover.
- fmt is sampled into stage 1 with its operands; changing fmt between products is legal.
- drain during reset: ignored; reset dominates.

Optional Feature:
- PE_MX_SAT_EN defined:
  - acc_next saturates to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)-1).
  - Any saturation or magnitude clamp sets sticky ovf until clear or reset.
- PE_MX_SAT_EN undefined:
  - The alignment clamp still applies.
  - The accumulator wraps modulo 2^ACC_W.
  - ovf is tied to 0.

Test Plan:
- E4M3 basic: fmt=0, a=0x38, b=0x38, in_valid for 1 cycle, drain one cycle later -> c_out=0x000100, c_valid pulses once; a_out/b_out show 0x38 one cycle after input.
- Sign mix: 0x38*0xB8, then 0x40*0x38 on consecutive cycles -> accumulator goes -256 then +256; drain gives 0x000100.
- E5M2 and subnormal:
  - fmt=1, a=0x3C, b=0x40 -> 512 (0x000200).
  - fmt=0, a=0x08, b=0x38 -> 4.
  - fmt=0, a=0x01, b=0x38 -> 0 (truncation).
- Specials: fmt=0, a=0x7F, b=0x38 -> acc unchanged, nan_seen=1; clear -> nan_seen=0.
- Overflow: fmt=1, a=b=0x7B twice:
  - With PE_MX_SAT_EN: c_out=0x7FFFFF, ovf=1.
  - Without: c_out=0xFFFFFE, ovf=0.
- Control corners:
  - Accumulate 3 products, then clear+drain together with a new product -> c_out = old sum; next drain = new product only.
  - rst low mid-stream -> all outputs 0 the next cycle; a product in stage 1 is lost.

Source files
------------

// File: rtl/pe_mx.sv
// FP8 (E4M3/E5M2) systolic multiply-accumulate PE with drain handshake.
// Define PE_MX_SAT_EN for a saturating accumulator with a sticky ovf flag.
module pe_mx #(
    parameter int ACC_W     = 24,
    parameter int FRAC_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fmt,
    input  logic             in_valid,
    input  logic [7:0]       a_in,
    input  logic [7:0]       b_in,
    output logic [7:0]       a_out,
    output logic [7:0]       b_out,
    output logic             valid_out,
    input  logic             drain,
    output logic [ACC_W-1:0] c_out,
    output logic             c_valid,
    output logic             nan_seen,
    output logic             ovf
);
    localparam logic [ACC_W-1:0] MAG_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    function automatic logic [3:0] sig_of(input logic [7:0] x, input logic f);
        if (f) return {|x[6:2], x[1:0], 1'b0};
        return {|x[6:3], x[2:0]};
    endfunction

    function automatic logic [4:0] exp_of(input logic [7:0] x, input logic f);
        logic [4:0] e;
        e = f ? x[6:2] : {1'b0, x[6:3]};
        return (e == 5'd0) ? 5'd1 : e;
    endfunction

    function automatic logic is_special(input logic [7:0] x, input logic f);
        return f ? (&x[6:2]) : (&x[6:0]);
    endfunction

    // Any shift that reaches the sign bit clamps, so a 64-bit window is enough.
    function automatic logic [ACC_W-1:0] align(input logic [7:0] p, input logic signed [9:0] s);
        logic [63:0] wide;
        int sh;
        sh = int'(s);
        if (sh < 0) return (-sh >= 8) ? '0 : ACC_W'(p >> -sh);
        if (sh >= ACC_W - 1) return (p == 8'd0) ? '0 : MAG_MAX;
        wide = 64'(p) << sh;
        return (wide > 64'(MAG_MAX)) ? MAG_MAX : wide[ACC_W-1:0];
    endfunction

`ifdef PE_MX_SAT_EN
    function automatic logic clamps(input logic [7:0] p, input logic signed [9:0] s);
        int sh;
        sh = int'(s);
        if (sh < 0 || p == 8'd0) return 1'b0;
        if (sh >= ACC_W - 1) return 1'b1;
        return (64'(p) << sh) > 64'(MAG_MAX);
    endfunction

    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] m, input logic neg);
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] lim;
        lim = $signed({1'b0, MAG_MAX});
        sum = neg ? ($signed({a[ACC_W-1], a}) - $signed({1'b0, m}))
                  : ($signed({a[ACC_W-1], a}) + $signed({1'b0, m}));
        if (sum > lim) return {1'b1, MAG_MAX};
        if (sum < -lim) return {1'b1, ACC_W'(-lim)};
        return {1'b0, sum[ACC_W-1:0]};
    endfunction
`endif

    logic [4:0]              ea, eb;
    int                      bias;
    logic                    spec_c;
    logic [7:0]              prod_c;
    logic signed [9:0]       shift_c;
    logic                    vld_p1, sign_p1, spec_p1;
    logic [7:0]              prod_p1;
    logic signed [9:0]       shift_p1;
    logic [ACC_W-1:0]        mag_p2;
    logic signed [ACC_W-1:0] acc, acc_next;

    always_comb begin
        bias    = fmt ? 15 : 7;
        ea      = exp_of(a_in, fmt);
        eb      = exp_of(b_in, fmt);
        spec_c  = is_special(a_in, fmt) | is_special(b_in, fmt);
        prod_c  = spec_c ? 8'd0 : sig_of(a_in, fmt) * sig_of(b_in, fmt);
        shift_c = 10'(int'(ea) + int'(eb) - 2 * bias - 6 + FRAC_BITS);
    end

    // Stage 1: decode/multiply register plus east/south forwarding
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_out     <= '0;
            b_out     <= '0;
            valid_out <= 1'b0;
            vld_p1    <= 1'b0;
            sign_p1   <= 1'b0;
            spec_p1   <= 1'b0;
            prod_p1   <= '0;
            shift_p1  <= '0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            valid_out <= in_valid;
            vld_p1    <= in_valid;
            sign_p1   <= in_valid & (a_in[7] ^ b_in[7]);
            spec_p1   <= in_valid & spec_c;
            prod_p1   <= in_valid ? prod_c : 8'd0;
            shift_p1  <= in_valid ? shift_c : 10'sd0;
        end
    end

    // Stage 2: align and accumulate
`ifdef PE_MX_SAT_EN
    logic sat_evt, ovf_evt;
    always_comb begin
        mag_p2              = vld_p1 ? align(prod_p1, shift_p1) : '0;
        {sat_evt, acc_next} = sat_add(acc, mag_p2, sign_p1);
        ovf_evt             = vld_p1 & (sat_evt | clamps(prod_p1, shift_p1));
    end

    always_ff @(posedge clk) begin
        if (!rst) ovf <= 1'b0;
        else      ovf <= clear ? 1'b0 : (ovf | ovf_evt);
    end
`else
    always_comb begin
        mag_p2   = vld_p1 ? align(prod_p1, shift_p1) : '0;
        acc_next = sign_p1 ? (acc - $signed(mag_p2)) : (acc + $signed(mag_p2));
    end

    assign ovf = 1'b0;
`endif

    // Drain snapshots the pre-clear sum so clear+drain turns a tile over seamlessly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc      <= '0;
            nan_seen <= 1'b0;
            c_out    <= '0;
            c_valid  <= 1'b0;
        end else begin
            acc      <= clear ? '0 : acc_next;
            nan_seen <= clear ? 1'b0 : (nan_seen | (vld_p1 & spec_p1));
            c_valid  <= drain;
            if (drain) c_out <= acc_next;
        end
    end
endmodule

// File: tb/tb_pe_mx.sv
// Directed bench for pe_mx: formats, subnormals, specials, overflow and control corners.
module tb_pe_mx;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst, clear, fmt, in_valid, drain;
    logic [7:0]       a_in, b_in, a_out, b_out;
    logic             valid_out, c_valid, nan_seen, ovf;
    logic [ACC_W-1:0] c_out;
    int               passed = 0;
    int               total  = 0;

    pe_mx #(.ACC_W(ACC_W), .FRAC_BITS(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .fmt(fmt), .in_valid(in_valid),
        .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out), .valid_out(valid_out),
        .drain(drain), .c_out(c_out), .c_valid(c_valid), .nan_seen(nan_seen), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one cycle of inputs, clock it, then sample 1 time unit after the edge.
    task automatic go(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic f, input logic clr, input logic drn);
        in_valid = v; a_in = a; b_in = b; fmt = f; clear = clr; drain = drn;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a_in = 8'h00; b_in = 8'h00; clear = 1'b0; drain = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; fmt = 1'b0; in_valid = 1'b0; drain = 1'b0;
        a_in = 8'h00; b_in = 8'h00;
        go(1, 8'h38, 8'h38, 0, 0, 1);
        go(0, 8'h00, 8'h00, 0, 0, 1);
        chk("rst_c_out", 32'(c_out), 32'h0);
        chk("rst_c_valid", 32'(c_valid), 32'h0);
        chk("rst_a_out", 32'(a_out), 32'h0);
        chk("rst_valid_out", 32'(valid_out), 32'h0);
        chk("rst_nan", 32'(nan_seen), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst = 1'b1;

        // E4M3 1.0 * 1.0
        go(1, 8'h38, 8'h38, 0, 0, 0);
        chk("fwd_a_out", 32'(a_out), 32'h38);
        chk("fwd_b_out", 32'(b_out), 32'h38);
        chk("fwd_valid_out", 32'(valid_out), 32'h1);
        chk("basic_c_valid_pre", 32'(c_valid), 32'h0);
        go(0, 8'h00, 8'h00, 0, 0, 1);
        chk("basic_c_out", 32'(c_out), 32'h000100);
        chk("basic_c_valid", 32'(c_valid), 32'h1);
        chk("basic_valid_out_low", 32'(valid_out), 32'h0);
        go(0, 8'h00, 8'h00, 0, 0, 0);
        chk("basic_c_valid_drop", 32'(c_valid), 32'h0);
        chk("basic_c_out_hold", 32'(c_out), 32'h000100);
        go(0, 8'h00, 8'h00, 0, 1, 0);

        // -256 then +512
        go(1, 8'h38, 8'hB8, 0, 0, 0);
        go(1, 8'h40, 8'h38, 0, 0, 1);
        chk("signmix_neg", 32'(c_out), 32'h00FFFF00);
        go(0, 8'h00, 8'h00, 0, 0, 1);
        chk("signmix_pos", 32'(c_out), 32'h000100);
        go(0, 8'h00, 8'h00, 0, 1, 0);

        go(1, 8'h3C, 8'h40, 1, 0, 0);
        go(0, 8'h00, 8'h00, 0, 0, 1);
        chk("e5m2_512", 32'(c_out), 32'h000200);
        go(0, 8'h00, 8'h00, 0, 1, 0);

        go(1, 8'h08, 8'h38, 0, 0, 0);
        go(0, 8'h00, 8'h00, 0, 0, 1);
        chk("min_normal_4", 32'(c_out), 32'h000004);
        go(0, 8'h00, 8'h00, 0, 1, 0);

        go(1, 8'h01, 8'h38, 0, 0, 0);
        go(0, 8'h00, 8'h00, 0, 0, 1);
        chk("subnormal_trunc", 32'(c_out), 32'h0);
        go(0, 8'h00, 8'h00, 0, 1, 0);

        // Specials contribute nothing but raise nan_seen on retirement
        go(1, 8'h38, 8'h38, 0, 0, 0);
        go(1, 8'h7F, 8'h38, 0, 0, 0);
        chk("nan_not_yet", 32'(nan_seen), 32'h0);
        go(0, 8'h00, 8'h00, 0, 0, 1);
        chk("nan_acc_unchanged", 32'(c_out), 32'h000100);
        chk("nan_set", 32'(nan_seen), 32'h1);
        go(0, 8'h00, 8'h00, 0, 1, 0);
        chk("nan_cleared", 32'(nan_seen), 32'h0);
        go(1, 8'h7C, 8'h3C, 1, 0, 0);
        go(0, 8'h00, 8'h00, 0, 0, 0);
        chk("nan_e5m2_inf", 32'(nan_seen), 32'h1);
        go(0, 8'h00, 8'h00, 0, 1, 0);

        // 0x7B*0x7B in E5M2 clamps the aligned magnitude
        go(1, 8'h7B, 8'h7B, 1, 0, 0);
        go(1, 8'h7B, 8'h7B, 1, 0, 0);
        go(0, 8'h00, 8'h00, 0, 0, 1);
`ifdef PE_MX_SAT_EN
        chk("ovf_c_out", 32'(c_out), 32'h7FFFFF);
        chk("ovf_flag", 32'(ovf), 32'h1);
`else
        chk("ovf_c_out", 32'(c_out), 32'hFFFFFE);
        chk("ovf_flag", 32'(ovf), 32'h0);
`endif
        go(0, 8'h00, 8'h00, 0, 1, 0);
        chk("ovf_cleared", 32'(ovf), 32'h0);

        // 256 + 512 + 4, then clear+drain alongside a new E5M2 product
        go(1, 8'h38, 8'h38, 0, 0, 0);
        go(1, 8'h40, 8'h38, 0, 0, 0);
        go(1, 8'h08, 8'h38, 0, 0, 0);
        go(0, 8'h00, 8'h00, 0, 0, 0);
        go(1, 8'h3C, 8'h40, 1, 1, 1);
        chk("turnover_old_sum", 32'(c_out), 32'h000304);
        chk("turnover_c_valid", 32'(c_valid), 32'h1);
        go(0, 8'h00, 8'h00, 0, 0, 1);
        chk("turnover_new_only", 32'(c_out), 32'h000200);

        // Reset mid-stream: the product in stage 1 is lost
        go(1, 8'h38, 8'h38, 0, 0, 0);
        rst = 1'b0;
        go(1, 8'h40, 8'h38, 0, 0, 1);
        chk("midrst_c_out", 32'(c_out), 32'h0);
        chk("midrst_a_out", 32'(a_out), 32'h0);
        chk("midrst_valid_out", 32'(valid_out), 32'h0);
        chk("midrst_c_valid", 32'(c_valid), 32'h0);
        rst = 1'b1;
        go(0, 8'h00, 8'h00, 0, 0, 1);
        chk("midrst_lost", 32'(c_out), 32'h0);
        chk("midrst_drain_pulse", 32'(c_valid), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
